instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, legal range 2..4: number of instruction buffer entries.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port mem_req_valid, output, 1: fetch request valid.
REQ-006 SHALL have port mem_req_ready, input, 1: memory accepts request.
REQ-007 SHALL have port mem_req_addr, output, 32: fetch address, word aligned.
REQ-008 SHALL have port mem_resp_valid, input, 1: response data valid.
REQ-009 SHALL have port mem_resp_data, input, 32: fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1: core jump/branch taken.
REQ-011 SHALL have port redirect_addr, input, 32: jump target.
REQ-012 SHALL have port instr_valid, output, 1: buffer head valid for the core.
REQ-013 SHALL have port instr_ready, input, 1: core consumes head.
REQ-014 SHALL have port instr, output, 32: head instruction word.
REQ-015 SHALL have port instr_pc, output, 32: address of head instruction.

Function
REQ-016 SHALL hold fetch_pc; a request handshake (mem_req_valid & mem_req_ready) SHALL advance fetch_pc by 4, mod 2^32; wrap 32'hFFFFFFFC->0 is allowed.
REQ-017 SHALL permit at most one outstanding request; FSM states: REQ (mem_req_valid=1), WAIT (request accepted, data pending), DROP (pending response to be discarded).
REQ-018 SHALL assert mem_req_valid in REQ only when buffer count < DEPTH; otherwise it SHALL stay in REQ with mem_req_valid=0.
REQ-019 SHALL move REQ->WAIT on handshake, WAIT->REQ on mem_resp_valid, and DROP->REQ on mem_resp_valid.
REQ-020 SHALL keep mem_req_addr and mem_req_valid stable while mem_req_valid=1 and mem_req_ready=0, unless redirect_valid=1.
REQ-021 SHALL push {mem_resp_data, request address} into the buffer on mem_resp_valid in WAIT; the response may arrive in the cycle after the handshake, or later.
REQ-022 SHALL register buffer outputs: a word pushed at edge N SHALL appear with instr_valid=1 in the cycle after edge N; no response-to-output bypass.
REQ-023 SHALL pop the head on instr_valid & instr_ready; a push and a pop in the same cycle SHALL both take effect, count unchanged.
REQ-024 SHALL, on redirect_valid=1, set fetch_pc to {redirect_addr[31:2],2'b00} and empty the buffer, with priority over every other event that cycle.
REQ-025 SHALL, on redirect in WAIT, or in REQ coinciding with a handshake, enter DROP.
REQ-026 SHALL, on redirect in WAIT when mem_resp_valid=1 in the same cycle, discard that response and enter REQ.
REQ-027 SHALL, on redirect in DROP, update fetch_pc and remain in DROP.
REQ-028 SHALL, on redirect in REQ without a handshake, remain in REQ; the new address SHALL be presented from the next cycle.
REQ-029 SHALL never push a discarded response and never issue a new request before the DROP response returns.
REQ-030 SHALL ignore mem_resp_valid in REQ; this is a protocol error with no state change.

Reset
REQ-031 SHALL, with rst=0 at a clock edge, set fetch_pc=RESET_PC, FSM=REQ, buffer empty, and discard any outstanding request.
REQ-032 SHALL drive mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0 and mem_req_addr=RESET_PC during the cycle after a reset edge.
REQ-033 SHALL begin requesting in the first cycle after rst returns to 1.

Verification
REQ-034 Reset release, memory always ready, 1-cycle response of 32'h00000413 -> request at 32'h80000000, then instr_valid with instr=32'h00000413 and instr_pc=32'h80000000 two cycles after the handshake.
REQ-035 instr_ready=0 with DEPTH=2 -> exactly 2 words buffered, mem_req_valid=0; one pop -> the next request issues in the following cycle.
REQ-036 Redirect to 32'h80000103 while in WAIT -> late response discarded, next request addr=32'h80000100, buffer empty.
REQ-037 Redirect in the same cycle as mem_resp_valid -> data not pushed, next request addr is the redirect target.
REQ-038 mem_req_ready held 0 for 3 cycles -> mem_req_addr stable, fetch_pc not advanced.
REQ-039 Reset asserted mid-WAIT with a stray response afterwards -> buffer stays empty, first post-reset request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, a small in-order
// instruction buffer with registered outputs, and redirect handling.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   req_pc_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] push_idx_s;
  logic [31:0]   data_q_r [DEPTH];
  logic [31:0]   pc_q_r   [DEPTH];
  logic          req_valid_r;
  logic          instr_valid_r;
  logic          handshake_s;
  logic          push_s;
  logic          pop_s;

  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = fetch_pc_r;
  assign instr_valid   = instr_valid_r;
  assign instr         = data_q_r[0];
  assign instr_pc      = pc_q_r[0];

  // Next-state, occupancy and buffer-control decode; redirect dominates all events.
  always_comb begin
    handshake_s = req_valid_r & mem_req_ready;
    pop_s       = instr_valid_r & instr_ready & ~redirect_valid;
    push_s      = (state_r == ST_WAIT) & mem_resp_valid & ~redirect_valid;
    push_idx_s  = count_r;
    if (pop_s) begin
      push_idx_s = count_r - CW'(1'b1);
    end else begin
      push_idx_s = count_r;
    end
    count_nxt_s = count_r;
    if (redirect_valid) begin
      count_nxt_s = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1'b1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
    state_nxt_s = state_r;
    case (state_r)
      ST_REQ: begin
        if (handshake_s) begin
          state_nxt_s = redirect_valid ? ST_DROP : ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt_s = ST_REQ;
        end else if (redirect_valid) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      // A response arriving in DROP always retires the stale request, even
      // alongside a fresh redirect; otherwise DROP would never be left.
      ST_DROP: begin
        if (mem_resp_valid) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase
  end

  // FSM, fetch PC, registered request/valid outputs and the shifting instruction buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_REQ;
      fetch_pc_r    <= RESET_PC;
      req_pc_r      <= RESET_PC;
      count_r       <= {CW{1'b0}};
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q_r[i] <= 32'h0000_0000;
        pc_q_r[i]   <= 32'h0000_0000;
      end
    end else begin
      state_r       <= state_nxt_s;
      count_r       <= count_nxt_s;
      req_valid_r   <= (state_nxt_s == ST_REQ) && (count_nxt_s < CW'(DEPTH));
      instr_valid_r <= (count_nxt_s != {CW{1'b0}});
      if (redirect_valid) begin
        fetch_pc_r <= {redirect_addr[31:2], 2'b00};
      end else if (handshake_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (handshake_s) begin
        req_pc_r <= fetch_pc_r;
      end
      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          data_q_r[i] <= data_q_r[i+1];
          pc_q_r[i]   <= pc_q_r[i+1];
        end
        data_q_r[DEPTH-1] <= 32'h0000_0000;
        pc_q_r[DEPTH-1]   <= 32'h0000_0000;
      end
      if (push_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == push_idx_s) begin
            data_q_r[i] <= mem_resp_data;
            pc_q_r[i]   <= req_pc_r;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed protocol scenarios followed by randomized
// traffic checked against a sequential-stream scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_req;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_dly;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic [31:0] sb_pc;

  // Memory contents as a fixed function of address; fmem(80000000) = 00000413.
  function automatic logic [31:0] fmem(input logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // After a redirect or reset the core must see a sequential stream from the target.
  task automatic model_flush(input logic [31:0] start);
    logic [31:0] a;
    a = start & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
    exp_req = start & 32'hFFFF_FFFC;
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_addr = 32'h0; instr_ready = 1'b0;
    pend = 1'b0; pend_dly = 0;
    model_flush(RESET_PC);
    nc(); nc();
    rst = 1'b1;
  endtask

  // One randomized cycle: memory responder, core backpressure, occasional redirect.
  int since_redir = 0;
  task automatic drive_random();
    logic        hs;
    logic [31:0] t;
    int          sel;
    mem_resp_valid = 1'b0;
    mem_resp_data  = $urandom;
    if (pend) begin
      if (pend_dly == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = fmem(pend_addr);
        pend = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    mem_req_ready = ($urandom % 4) != 0;
    instr_ready   = ($urandom % 3) != 0;
    hs = mem_req_valid && mem_req_ready;
    if (hs) begin
      check_bit("one_outstanding", pend, 1'b0);
      check("req_addr", mem_req_addr, exp_req);
      exp_req   = exp_req + 32'd4;
      pend      = 1'b1;
      pend_addr = mem_req_addr;
      pend_dly  = $urandom % 4;
    end
    since_redir++;
    if (since_redir >= 300 || ($urandom % 24) == 0) begin
      sel = $urandom % 3;
      t   = $urandom;
      if (sel == 0) t = 32'h8000_0000 | (t & 32'h0000_0FFF);
      else if (sel == 1) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
      redirect_valid = 1'b1;
      redirect_addr  = t;
      model_flush(t);
      since_redir = 0;
    end else begin
      redirect_valid = 1'b0;
    end
  endtask

  // Monitor: retire consumed instructions against the scoreboard, and check request stability.
  initial begin
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (rst && instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check_bit("sb_underflow", 1'b0, 1'b1);
        end else begin
          sb_pc = exp_q.pop_front();
          check("instr_pc", instr_pc, sb_pc);
          check("instr", instr, fmem(sb_pc));
        end
      end
      if (rst && prev_stall) begin
        check_bit("req_hold_valid", mem_req_valid, 1'b1);
        check("req_hold_addr", mem_req_addr, prev_addr);
      end
      prev_stall = rst && mem_req_valid && !mem_req_ready && !redirect_valid;
      prev_addr  = mem_req_addr;
    end
  end

  initial begin
    rst = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_addr = 32'h0; instr_ready = 1'b0;
    pend = 1'b0; pend_dly = 0; pend_addr = 32'h0;
    model_flush(RESET_PC);
    nc(); nc();
    check_bit("rst_req_valid", mem_req_valid, 1'b0);
    check_bit("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req_addr", mem_req_addr, RESET_PC);

    rst = 1'b1; mem_req_ready = 1'b1;
    nc();
    check_bit("first_req_valid", mem_req_valid, 1'b1);
    check("first_req_addr", mem_req_addr, 32'h8000_0000);
    nc();
    check_bit("wait_no_req", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = fmem(32'h8000_0000);
    nc();
    mem_resp_valid = 1'b0;
    check_bit("lat_instr_valid", instr_valid, 1'b1);
    check("lat_instr", instr, 32'h0000_0413);
    check("lat_instr_pc", instr_pc, 32'h8000_0000);
    check_bit("second_req_valid", mem_req_valid, 1'b1);
    check("second_req_addr", mem_req_addr, 32'h8000_0004);
    nc();
    check_bit("wait2_no_req", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = fmem(32'h8000_0004);
    nc();
    mem_resp_valid = 1'b0;
    check_bit("full_instr_valid", instr_valid, 1'b1);
    check("full_head_pc", instr_pc, 32'h8000_0000);
    check_bit("full_no_req", mem_req_valid, 1'b0);
    nc();
    check_bit("full_no_req2", mem_req_valid, 1'b0);
    instr_ready = 1'b1;
    nc();
    instr_ready = 1'b0; mem_req_ready = 1'b0;
    check_bit("pop_req_valid", mem_req_valid, 1'b1);
    check("pop_req_addr", mem_req_addr, 32'h8000_0008);
    check("pop_head_pc", instr_pc, 32'h8000_0004);
    for (int k = 0; k < 3; k++) begin
      nc();
      check_bit("stall_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, 32'h8000_0008);
    end
    mem_req_ready = 1'b1;
    nc();
    check_bit("wait3_no_req", mem_req_valid, 1'b0);
    redirect_valid = 1'b1; redirect_addr = 32'h8000_0103;
    model_flush(32'h8000_0100);
    nc();
    redirect_valid = 1'b0;
    check_bit("redir_flush", instr_valid, 1'b0);
    check_bit("drop_no_req", mem_req_valid, 1'b0);
    nc();
    check_bit("drop_no_req2", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = fmem(32'h8000_0008);
    nc();
    mem_resp_valid = 1'b0;
    check_bit("drop_not_pushed", instr_valid, 1'b0);
    check_bit("after_drop_req", mem_req_valid, 1'b1);
    check("after_drop_addr", mem_req_addr, 32'h8000_0100);
    nc();
    check_bit("wait4_no_req", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_data = fmem(32'h8000_0100);
    redirect_valid = 1'b1; redirect_addr = 32'h8000_0200;
    model_flush(32'h8000_0200);
    nc();
    mem_resp_valid = 1'b0; redirect_valid = 1'b0;
    check_bit("redir_resp_not_pushed", instr_valid, 1'b0);
    check_bit("redir_resp_req", mem_req_valid, 1'b1);
    check("redir_resp_addr", mem_req_addr, 32'h8000_0200);
    nc();
    check_bit("wait5_no_req", mem_req_valid, 1'b0);
    rst = 1'b0;
    model_flush(RESET_PC);
    nc();
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = fmem(32'h8000_0200);
    check_bit("midrst_req_valid", mem_req_valid, 1'b0);
    check_bit("midrst_instr_valid", instr_valid, 1'b0);
    check("midrst_addr", mem_req_addr, RESET_PC);
    nc();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    check_bit("stray_not_pushed", instr_valid, 1'b0);
    check_bit("postrst_req_valid", mem_req_valid, 1'b1);
    check("postrst_req_addr", mem_req_addr, RESET_PC);
    nc();
    check_bit("stray_not_pushed2", instr_valid, 1'b0);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      nc();
      drive_random();
    end
    nc();
    redirect_valid = 1'b0; mem_resp_valid = 1'b0;
    nc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
